scsp_timer_bank: RTL and testbench

- Parametrised successor to the three fixed SCSP timers (TIMA/TIMB/TIMC with TACTL/TBCTL/TCCTL).
- Holds NUM_TIMERS up-counters, each with a power-of-two sample prescaler.
- Owns the interrupt enable/pending/reset register (SCIEB/SCIPD/SCIRE style) and drives one interrupt request.
- Sits beside the slot pipeline; the register-bus decoder writes it and reads it back. Other blocks post events through EXT_SET.

---
 rtl/scsp_timer_bank_pkg.sv | 31 +++
 rtl/scsp_timer_cell.sv | 63 ++++++
 rtl/scsp_timer_bank.sv | 81 ++++++++
 tb/tb_scsp_timer_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scsp_timer_bank_pkg.sv
// Shared SCSP timer/interrupt definitions: defaults, interrupt bit map,
// timer control record and prescaler sizing helper.
package scsp_timer_bank_pkg;

   localparam int TIMER_NUM_DEF  = 3;
   localparam int TIMER_IRQ_BASE = 6;
   localparam int TIMER_CNT_DEF  = 8;
   localparam int TIMER_CTL_DEF  = 3;
   localparam int PEND_W_DEF     = 11;

   // Interrupt bit positions in the enable/pending/reset registers
   localparam int IRQ_MIDI_IN  = 3;
   localparam int IRQ_DMA_END  = 4;
   localparam int IRQ_TIMER_A  = 6;
   localparam int IRQ_TIMER_B  = 7;
   localparam int IRQ_TIMER_C  = 8;
   localparam int IRQ_MIDI_OUT = 9;
   localparam int IRQ_SAMPLE   = 10;

   // Register image of one timer as seen on the bus (TxCTL + count)
   typedef struct packed {
      logic [TIMER_CTL_DEF-1:0] ctl;
      logic [TIMER_CNT_DEF-1:0] count;
   } TimerCtl_t;

   // Prescaler must divide by up to 2**(2**ctl_w - 1)
   function automatic int presc_width(int ctl_w);
      return (1 << ctl_w) - 1;
   endfunction

endpackage

// File: rtl/scsp_timer_cell.sv
// One timer: sample prescaler, up-counter and one-cycle overflow pulse.
// 'wrap' flags, combinationally, that the current CE cycle will wrap the
// count so the parent can set its pending bit in the same register stage.
module scsp_timer_cell
   import scsp_timer_bank_pkg::*;
#(
   parameter int CNT_W = TIMER_CNT_DEF,
   parameter int CTL_W = TIMER_CTL_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             tick,
   input  logic             wr,
   input  logic [CNT_W-1:0] di,
   input  logic [CTL_W-1:0] ctl_di,
   output logic [CNT_W-1:0] count,
   output logic [CTL_W-1:0] ctl,
   output logic             ovf,
   output logic             wrap
);

   localparam int PR_W = presc_width(CTL_W);

   logic [PR_W-1:0] presc;
   logic [PR_W-1:0] presc_n;
   logic [PR_W:0]   one_sh;
   logic [PR_W-1:0] step_mask;
   logic            step;

   // Step when the low ctl bits of the advanced prescaler are all zero
   always_comb begin
      presc_n   = presc + PR_W'(1);
      one_sh    = {{PR_W{1'b0}}, 1'b1} << ctl;
      step_mask = one_sh[PR_W-1:0] - PR_W'(1);
      step      = ((presc_n & step_mask) == '0);
      wrap      = tick & ~wr & step & (&count);
   end

   // Load has priority over tick; ovf lasts exactly one CE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         ctl   <= '0;
         presc <= '0;
         ovf   <= 1'b0;
      end else if (ce) begin
         ovf <= 1'b0;
         if (wr) begin
            count <= di;
            ctl   <= ctl_di;
            presc <= '0;
         end else if (tick) begin
            presc <= presc_n;
            if (step) begin
               count <= count + CNT_W'(1);
               ovf   <= &count;
            end
         end
      end
   end

endmodule

// File: rtl/scsp_timer_bank.sv
// Bank of NUM_TIMERS sample timers plus the interrupt enable/pending/reset
// registers and the registered interrupt request.
module scsp_timer_bank
   import scsp_timer_bank_pkg::*;
#(
   parameter int NUM_TIMERS = TIMER_NUM_DEF,
   parameter int CNT_W      = TIMER_CNT_DEF,
   parameter int CTL_W      = TIMER_CTL_DEF,
   parameter int PEND_W     = PEND_W_DEF,
   parameter int IRQ_BASE   = TIMER_IRQ_BASE
)(
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        CE,
   input  logic                        SAMPLE_TICK,
   input  logic [NUM_TIMERS-1:0]       TIM_WR,
   input  logic [CNT_W-1:0]            TIM_DI,
   input  logic [CTL_W-1:0]            CTL_DI,
   input  logic                        IEB_WR,
   input  logic [PEND_W-1:0]           IEB_DI,
   input  logic                        PD_WR,
   input  logic [PEND_W-1:0]           PD_DI,
   input  logic                        RE_WR,
   input  logic [PEND_W-1:0]           RE_DI,
   input  logic [PEND_W-1:0]           EXT_SET,
   output logic [NUM_TIMERS*CNT_W-1:0] TIM_VAL,
   output logic [NUM_TIMERS*CTL_W-1:0] TIM_CTL,
   output logic [NUM_TIMERS-1:0]       TIM_OVF,
   output logic [PEND_W-1:0]           IEB,
   output logic [PEND_W-1:0]           PEND,
   output logic                        IRQ
);

   logic [NUM_TIMERS-1:0] wrap;
   logic [PEND_W-1:0]     ovf_set;
   logic [PEND_W-1:0]     pend_set;
   logic [PEND_W-1:0]     pend_clr;

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tim
      scsp_timer_cell #(
         .CNT_W (CNT_W),
         .CTL_W (CTL_W)
      ) u_cell (
         .clk    (CLK),
         .rst_n  (RST_N),
         .ce     (CE),
         .tick   (SAMPLE_TICK),
         .wr     (TIM_WR[i]),
         .di     (TIM_DI),
         .ctl_di (CTL_DI),
         .count  (TIM_VAL[i*CNT_W +: CNT_W]),
         .ctl    (TIM_CTL[i*CTL_W +: CTL_W]),
         .ovf    (TIM_OVF[i]),
         .wrap   (wrap[i])
      );
   end

   // Gather set/clear sources; a set always beats a same-cycle clear
   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         ovf_set[IRQ_BASE+i] = wrap[i];
      end
      pend_clr = RE_WR ? RE_DI : '0;
      pend_set = EXT_SET | (PD_WR ? PD_DI : '0) | ovf_set;
   end

   // Enable/pending registers; IRQ trails PEND/IEB by one CE cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         IEB  <= '0;
         PEND <= '0;
         IRQ  <= 1'b0;
      end else if (CE) begin
         if (IEB_WR) IEB <= IEB_DI;
         PEND <= (PEND & ~pend_clr) | pend_set;
         IRQ  <= |(PEND & IEB);
      end
   end

endmodule

// File: tb/tb_scsp_timer_bank.sv
// Self-checking bench for scsp_timer_bank: directed scenarios with literal
// expectations, a randomized phase, and a per-cycle compare against a
// behavioural model (tick counts since load, plain integer arithmetic).
module tb_scsp_timer_bank;

   localparam int NT = 3;
   localparam int CW = 8;
   localparam int LW = 3;
   localparam int PW = 11;
   localparam int IB = 6;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic CE = 1'b0;
   logic SAMPLE_TICK = 1'b0;
   logic [NT-1:0] TIM_WR = '0;
   logic [CW-1:0] TIM_DI = '0;
   logic [LW-1:0] CTL_DI = '0;
   logic IEB_WR = 1'b0;
   logic [PW-1:0] IEB_DI = '0;
   logic PD_WR = 1'b0;
   logic [PW-1:0] PD_DI = '0;
   logic RE_WR = 1'b0;
   logic [PW-1:0] RE_DI = '0;
   logic [PW-1:0] EXT_SET = '0;
   logic [NT*CW-1:0] TIM_VAL;
   logic [NT*LW-1:0] TIM_CTL;
   logic [NT-1:0] TIM_OVF;
   logic [PW-1:0] IEB, PEND;
   logic IRQ;

   // wide build: 5 timers, 10-bit counters
   logic [4:0]  b_wr = '0;
   logic [9:0]  b_di = '0;
   logic        b_tick = 1'b0;
   logic [49:0] b_val;
   logic [14:0] b_ctl;
   logic [4:0]  b_ovf;
   logic [PW-1:0] b_ieb, b_pend;
   logic b_irq;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   always #5 CLK = ~CLK;

   scsp_timer_bank dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .SAMPLE_TICK(SAMPLE_TICK),
      .TIM_WR(TIM_WR), .TIM_DI(TIM_DI), .CTL_DI(CTL_DI),
      .IEB_WR(IEB_WR), .IEB_DI(IEB_DI), .PD_WR(PD_WR), .PD_DI(PD_DI),
      .RE_WR(RE_WR), .RE_DI(RE_DI), .EXT_SET(EXT_SET),
      .TIM_VAL(TIM_VAL), .TIM_CTL(TIM_CTL), .TIM_OVF(TIM_OVF),
      .IEB(IEB), .PEND(PEND), .IRQ(IRQ)
   );

   scsp_timer_bank #(.NUM_TIMERS(5), .CNT_W(10)) dut_w (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .SAMPLE_TICK(b_tick),
      .TIM_WR(b_wr), .TIM_DI(b_di), .CTL_DI(3'd0),
      .IEB_WR(1'b0), .IEB_DI('0), .PD_WR(1'b0), .PD_DI('0),
      .RE_WR(1'b0), .RE_DI('0), .EXT_SET('0),
      .TIM_VAL(b_val), .TIM_CTL(b_ctl), .TIM_OVF(b_ovf),
      .IEB(b_ieb), .PEND(b_pend), .IRQ(b_irq)
   );

   // ---------------- behavioural model ----------------
   int m_cnt [NT];
   int m_ctl [NT];
   int m_tk  [NT];   // ticks seen since the last load
   logic [NT-1:0] m_ovf;
   logic [PW-1:0] m_pend, m_ieb;
   logic m_irq;

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         m_cnt[i] = 0; m_ctl[i] = 0; m_tk[i] = 0;
      end
      m_ovf = '0; m_pend = '0; m_ieb = '0; m_irq = 1'b0;
   endtask

   task automatic model_step();
      logic [PW-1:0] set;
      if (!CE) return;
      m_irq = |(m_pend & m_ieb);
      set = EXT_SET | (PD_WR ? PD_DI : '0);
      for (int i = 0; i < NT; i++) begin
         m_ovf[i] = 1'b0;
         if (TIM_WR[i]) begin
            m_cnt[i] = int'(TIM_DI); m_ctl[i] = int'(CTL_DI); m_tk[i] = 0;
         end else if (SAMPLE_TICK) begin
            m_tk[i]++;
            if (m_tk[i] % (1 << m_ctl[i]) == 0) begin
               if (m_cnt[i] == (1 << CW) - 1) begin
                  m_ovf[i] = 1'b1;
                  set[IB+i] = 1'b1;
               end
               m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            end
         end
      end
      m_pend = (m_pend & ~(RE_WR ? RE_DI : '0)) | set;
      if (IEB_WR) m_ieb = IEB_DI;
   endtask

   function automatic logic [NT*CW-1:0] exp_val();
      logic [NT*CW-1:0] v;
      for (int i = 0; i < NT; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
      return v;
   endfunction

   function automatic logic [NT*LW-1:0] exp_ctl();
      logic [NT*LW-1:0] v;
      for (int i = 0; i < NT; i++) v[i*LW +: LW] = LW'(m_ctl[i]);
      return v;
   endfunction

   function automatic logic [CW-1:0] val(int i);
      return TIM_VAL[i*CW +: CW];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: model consumes the same inputs the DUT samples
   task automatic cyc();
      @(posedge CLK);
      if (RST_N) model_step();
      #1;
   endtask

   task automatic idle();
      SAMPLE_TICK = 1'b0; TIM_WR = '0; IEB_WR = 1'b0; PD_WR = 1'b0;
      RE_WR = 1'b0; EXT_SET = '0;
   endtask

   // per-cycle compare against the model
   always @(negedge CLK) begin
      if (RST_N && cmp_on) begin
         chk("m_val",  TIM_VAL, exp_val());
         chk("m_ctl",  TIM_CTL, exp_ctl());
         chk("m_ovf",  TIM_OVF, m_ovf);
         chk("m_ieb",  IEB,     m_ieb);
         chk("m_pend", PEND,    m_pend);
         chk("m_irq",  IRQ,     m_irq);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      #12;
      chk("rst_val",  TIM_VAL, 0);
      chk("rst_ctl",  TIM_CTL, 0);
      chk("rst_ovf",  TIM_OVF, 0);
      chk("rst_ieb",  IEB,     0);
      chk("rst_pend", PEND,    0);
      chk("rst_irq",  IRQ,     0);
      @(negedge CLK);
      RST_N = 1'b1; CE = 1'b1; cmp_on = 1'b1;
      cyc();

      // timer 0, ctl=0: FD -> FE -> FF -> 00
      TIM_WR = 3'b001; TIM_DI = 8'hFD; CTL_DI = 3'd0;
      cyc(); idle();
      chk("t0_load", val(0), 8'hFD);
      SAMPLE_TICK = 1'b1;
      cyc(); chk("t0_fe", val(0), 8'hFE);
      cyc(); chk("t0_ff", val(0), 8'hFF); chk("t0_noovf", TIM_OVF[0], 0);
      cyc(); chk("t0_wrap", val(0), 8'h00); chk("t0_ovf", TIM_OVF[0], 1);
      chk("t0_pend", PEND[6], 1);
      SAMPLE_TICK = 1'b0;
      cyc(); chk("t0_ovf_once", TIM_OVF[0], 0); chk("irq_disabled", IRQ, 0);
      IEB_WR = 1'b1; IEB_DI = 11'h040;
      cyc(); idle(); chk("irq_lag", IRQ, 0);
      cyc(); chk("irq_on", IRQ, 1);
      RE_WR = 1'b1; RE_DI = '1; IEB_WR = 1'b1; IEB_DI = '0;
      cyc(); idle(); chk("clr_all", PEND, 0);

      // timer 1, ctl=3: 8 ticks per step
      TIM_WR = 3'b010; TIM_DI = 8'hFF; CTL_DI = 3'd3;
      cyc(); idle();
      SAMPLE_TICK = 1'b1;
      repeat (7) cyc();
      chk("t1_hold", val(1), 8'hFF); chk("t1_nopend", PEND[7], 0);
      cyc(); chk("t1_wrap", val(1), 8'h00); chk("t1_pend", PEND[7], 1);
      repeat (3) cyc();
      TIM_WR = 3'b010; TIM_DI = 8'h80;
      cyc(); TIM_WR = '0;
      repeat (7) cyc(); chk("t1_reload_hold", val(1), 8'h80);
      cyc(); chk("t1_reload_step", val(1), 8'h81);
      idle();

      // timer 2: load beats a wrapping tick
      TIM_WR = 3'b100; TIM_DI = 8'hFF; CTL_DI = 3'd0; RE_WR = 1'b1; RE_DI = '1;
      cyc(); idle();
      SAMPLE_TICK = 1'b1; TIM_WR = 3'b100; TIM_DI = 8'h10;
      cyc(); idle();
      chk("t2_load_wins", val(2), 8'h10); chk("t2_noovf", TIM_OVF[2], 0);
      chk("t2_nopend", PEND[8], 0);

      // set beats same-cycle clear
      TIM_WR = 3'b001; TIM_DI = 8'hFF; PD_WR = 1'b1; PD_DI = 11'h040;
      cyc(); idle(); chk("pd_set", PEND[6], 1);
      SAMPLE_TICK = 1'b1; RE_WR = 1'b1; RE_DI = 11'h040;
      cyc(); idle(); chk("set_vs_clr_ovf", TIM_OVF[0], 1); chk("set_wins", PEND[6], 1);
      RE_WR = 1'b1; RE_DI = 11'h040;
      cyc(); idle(); chk("re_alone", PEND[6], 0);

      // external + PD sets, then full clear
      RE_WR = 1'b1; RE_DI = '1; cyc(); idle();
      EXT_SET = 11'h400; PD_WR = 1'b1; PD_DI = 11'h020;
      cyc(); idle(); chk("ext_pd", PEND, 11'h420);
      RE_WR = 1'b1; RE_DI = 11'h7FF;
      cyc(); idle(); chk("re_all", PEND, 0);

      // ticks only while CE=0 are ignored
      for (int k = 0; k < 20; k++) begin
         CE = (k % 2 == 0); SAMPLE_TICK = ~CE;
         cyc();
      end
      CE = 1'b1; SAMPLE_TICK = 1'b0;
      chk("ce_hold_t0", val(0), 8'h00); chk("ce_hold_t2", val(2), 8'h11);

      // wide build: timer 4 wraps 0x3FF -> 0, sets bit 10
      b_wr = 5'b10000; b_di = 10'h3FF;
      cyc(); b_wr = '0; b_tick = 1'b1;
      cyc(); b_tick = 1'b0;
      chk("w_t4_wrap", b_val[49:40], 0); chk("w_t4_ovf", b_ovf[4], 1);
      chk("w_pend", b_pend, 11'h400);

      // randomized phase, compared every cycle
      repeat (3000) begin
         CE = ($urandom % 8) != 0;
         SAMPLE_TICK = $urandom % 2;
         for (int i = 0; i < NT; i++) TIM_WR[i] = ($urandom % 12) == 0;
         TIM_DI = ($urandom % 2) ? (8'hF8 | 8'($urandom % 8)) : 8'($urandom);
         CTL_DI = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
         IEB_WR = ($urandom % 16) == 0; IEB_DI = PW'($urandom);
         PD_WR = ($urandom % 16) == 0; PD_DI = PW'($urandom);
         RE_WR = ($urandom % 6) == 0; RE_DI = PW'($urandom);
         EXT_SET = (($urandom % 16) == 0) ? PW'(1 << ($urandom % PW)) : '0;
         cyc();
      end
      idle(); CE = 1'b1;
      TIM_WR = 3'b111; TIM_DI = 8'h55; CTL_DI = 3'd0;
      cyc(); idle(); SAMPLE_TICK = 1'b1;
      cyc();

      // asynchronous reset mid-cycle
      #3 RST_N = 1'b0; model_reset();
      #1;
      chk("arst_val",  TIM_VAL, 0);
      chk("arst_ctl",  TIM_CTL, 0);
      chk("arst_ovf",  TIM_OVF, 0);
      chk("arst_pend", PEND,    0);
      chk("arst_ieb",  IEB,     0);
      chk("arst_irq",  IRQ,     0);
      #2 RST_N = 1'b1;
      cyc(); chk("post_rst_step", val(0), 8'h01);
      idle(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
